// File: rtl/shift_seq_ctrl.sv
// Command sequencer feeding an 8-bit shift register: buffers load/shift commands
// in a small FIFO and expands each into a load cycle and/or a counted shift run.
module shift_seq_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             flush,
  output logic             enable,
  output logic [1:0]       shift_direction,
  output logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [1:0] OP_LOAD     = 2'b00;
  localparam logic [1:0] OP_SHR      = 2'b10;
  localparam logic [1:0] OP_LOAD_SHL = 2'b11;

  localparam logic [1:0] DIR_SHL  = 2'b00;
  localparam logic [1:0] DIR_SHR  = 2'b10;
  localparam logic [1:0] DIR_LOAD = 2'b11;

  typedef struct packed {
    logic [1:0]       op;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] data;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, RETIRE} state_t;

  cmd_t             mem_q [DEPTH];
  cmd_t             mem_d [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             enable_q, enable_d;
  logic [1:0]       dir_q, dir_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             done_q, done_d;

  logic empty;
  logic full;
  logic push;
  logic pop;
  cmd_t head;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty     = (wptr_q == rptr_q);
  assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign cmd_ready = !full && !flush;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == IDLE) && !empty && !flush;
  assign head      = mem_q[rptr_q[AW-1:0]];
  assign busy      = !empty || (state_q != IDLE);

  // Command FIFO storage and pointers; flush drops every queued entry.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      mem_d[wptr_q[AW-1:0]] = '{op: cmd_op, count: cmd_count, data: cmd_data};
      wptr_d = wptr_q + (AW+1)'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + (AW+1)'(1);
    end
    if (flush) begin
      rptr_d = wptr_q;
    end
  end

  // Sequencer next state; outputs are derived from the next state so they line up with it.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          op_d  = head.op;
          rem_d = head.count;
          if (head.op == OP_LOAD || head.op == OP_LOAD_SHL) begin
            state_d = LOAD;
          end else if (head.count != '0) begin
            state_d = SHIFT;
          end else begin
            state_d = RETIRE;
          end
        end
      end
      LOAD: begin
        state_d = (op_q == OP_LOAD_SHL && rem_q != '0) ? SHIFT : RETIRE;
      end
      SHIFT: begin
        if (rem_q != '0) begin
          rem_d = rem_q - CNT_W'(1);
        end
        if (rem_q <= CNT_W'(1)) begin
          state_d = RETIRE;
        end
      end
      RETIRE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (flush) begin
      state_d = IDLE;
    end

    enable_d = (state_d == LOAD) || (state_d == SHIFT);
    dir_d    = DIR_SHL;
    if (state_d == LOAD) begin
      dir_d = DIR_LOAD;
    end else if (state_d == SHIFT && op_d == OP_SHR) begin
      dir_d = DIR_SHR;
    end
    data_d = (pop && state_d == LOAD) ? head.data : data_q;
    done_d = (state_d == RETIRE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q   <= '0;
      rptr_q   <= '0;
      state_q  <= IDLE;
      op_q     <= '0;
      rem_q    <= '0;
      enable_q <= 1'b0;
      dir_q    <= DIR_SHL;
      data_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      state_q  <= state_d;
      op_q     <= op_d;
      rem_q    <= rem_d;
      enable_q <= enable_d;
      dir_q    <= dir_d;
      data_q   <= data_d;
      done_q   <= done_d;
    end
  end

  assign enable          = enable_q;
  assign shift_direction = dir_q;
  assign data_in         = data_q;
  assign done            = done_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl: expected enable cycles and run lengths are
// queued on accept and consumed by a negedge monitor; timing checks use cycle logs.
module tb_shift_seq_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned DEPTH = 4;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHL  = 2'b01;
  localparam logic [1:0] OP_SHR  = 2'b10;
  localparam logic [1:0] OP_LSHL = 2'b11;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] cmd_data;
  logic             flush;
  logic             enable;
  logic [1:0]       shift_direction;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic             done;

  shift_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_count(cmd_count), .cmd_data(cmd_data), .flush(flush),
    .enable(enable), .shift_direction(shift_direction), .data_in(data_in),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0]       exp_q[$];
  int               done_q[$];
  logic [WIDTH-1:0] last_load = '0;
  logic [WIDTH-1:0] sr_model  = '0;
  int               run_cnt   = 0;

  logic       en_log[$];
  logic [1:0] dir_log[$];
  logic       done_log[$];
  logic       busy_log[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    en_log.delete();
    dir_log.delete();
    done_log.delete();
    busy_log.delete();
  endtask

  // Queue the enable cycles and run length a command should produce.
  task automatic expect_cmd(input logic [1:0] op, input logic [CNT_W-1:0] cnt, input logic [WIDTH-1:0] d);
    int n_sh;
    int total;
    total = 0;
    if (op == OP_LOAD || op == OP_LSHL) begin
      exp_q.push_back({2'b11, d});
      last_load = d;
      total++;
    end
    n_sh = (op == OP_LOAD) ? 0 : int'(cnt);
    for (int i = 0; i < n_sh; i++) begin
      exp_q.push_back({(op == OP_SHR) ? 2'b10 : 2'b00, last_load});
      total++;
    end
    done_q.push_back(total);
  endtask

  task automatic send(input logic [1:0] op, input logic [CNT_W-1:0] cnt, input logic [WIDTH-1:0] d,
                      output int waited);
    waited    = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = cnt;
    cmd_data  = d;
    #1;
    while (!cmd_ready && waited < 100) begin
      tick();
      waited++;
    end
    check_eq("send_accept", 32'(cmd_ready), 32'(1));
    if (cmd_ready) expect_cmd(op, cnt, d);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    tick();
    check_eq(tag, 32'(busy), 32'(0));
  endtask

  task automatic monitor_loop();
    logic [9:0] e;
    int         n;
    forever begin
      @(negedge clk);
      en_log.push_back(enable);
      dir_log.push_back(shift_direction);
      done_log.push_back(done);
      busy_log.push_back(busy);
      if (enable) begin
        run_cnt++;
        check_eq("sb_enable_expected", 32'(exp_q.size() != 0), 32'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("sb_dir", 32'(shift_direction), 32'(e[9:8]));
          check_eq("sb_data_in", 32'(data_in), 32'(e[7:0]));
        end
        case (shift_direction)
          2'b11:   sr_model = data_in;
          2'b00:   sr_model = sr_model << 1;
          2'b10:   sr_model = sr_model >> 1;
          default: sr_model = sr_model;
        endcase
      end
      if (done) begin
        check_eq("sb_done_expected", 32'(done_q.size() != 0), 32'(1));
        if (done_q.size() != 0) begin
          n = done_q.pop_front();
          check_eq("sb_run_len", 32'(run_cnt), 32'(n));
        end
        run_cnt = 0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int first;
    int ones;
    int dones;
    logic       exp_en[5];
    logic [1:0] exp_dir[5];

    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_count = '0;
    cmd_data  = '0;
    flush     = 1'b0;

    // Reset values while held in reset
    #1 reset = 1'b0;
    #1;
    check_eq("rst_enable", 32'(enable), 32'(0));
    check_eq("rst_dir", 32'(shift_direction), 32'(0));
    check_eq("rst_data_in", 32'(data_in), 32'(0));
    check_eq("rst_done", 32'(done), 32'(0));
    check_eq("rst_busy", 32'(busy), 32'(0));
    check_eq("rst_ready", 32'(cmd_ready), 32'(1));
    fork
      monitor_loop();
    join_none
    tick();
    reset = 1'b1;
    tick();

    // LOAD_SHL A5 x3: one load cycle, three shift-left cycles, done after
    send(OP_LSHL, 3'd3, 8'hA5, w);
    check_eq("lshl_busy_after_accept", 32'(busy), 32'(1));
    check_eq("lshl_no_enable_yet", 32'(enable), 32'(0));
    tick();
    check_eq("lshl_load_en", 32'(enable), 32'(1));
    check_eq("lshl_load_dir", 32'(shift_direction), 32'(2'b11));
    check_eq("lshl_load_data", 32'(data_in), 32'(8'hA5));
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("lshl_shift_en", 32'(enable), 32'(1));
      check_eq("lshl_shift_dir", 32'(shift_direction), 32'(2'b00));
    end
    tick();
    check_eq("lshl_retire_en", 32'(enable), 32'(0));
    check_eq("lshl_done", 32'(done), 32'(1));
    tick();
    check_eq("lshl_done_once", 32'(done), 32'(0));
    check_eq("lshl_busy_low", 32'(busy), 32'(0));
    check_eq("lshl_model", 32'(sr_model), 32'(8'h28));

    // Back-to-back LOAD 81 then SHR 2
    clear_logs();
    send(OP_LOAD, 3'd0, 8'h81, w);
    send(OP_SHR, 3'd2, 8'h00, w);
    repeat (8) tick();
    first = -1;
    for (int i = 0; i < en_log.size(); i++) begin
      if (first < 0 && en_log[i]) first = i;
    end
    check_eq("b2b_found", 32'(first >= 0 && first + 5 <= en_log.size()), 32'(1));
    exp_en  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_dir = '{2'b11, 2'b00, 2'b00, 2'b10, 2'b10};
    if (first >= 0 && first + 5 <= en_log.size()) begin
      for (int i = 0; i < 5; i++) begin
        check_eq("b2b_enable", 32'(en_log[first+i]), 32'(exp_en[i]));
        check_eq("b2b_dir", 32'(dir_log[first+i]), 32'(exp_dir[i]));
      end
    end
    dones = 0;
    foreach (done_log[i]) dones += int'(done_log[i]);
    check_eq("b2b_done_pulses", 32'(dones), 32'(2));
    check_eq("b2b_model", 32'(sr_model), 32'(8'h20));

    // Zero-count shift: no enable, done on the pop cycle
    clear_logs();
    send(OP_SHL, 3'd0, 8'h00, w);
    repeat (4) tick();
    ones = 0;
    dones = 0;
    foreach (en_log[i]) ones += int'(en_log[i]);
    foreach (done_log[i]) dones += int'(done_log[i]);
    check_eq("zero_no_enable", 32'(ones), 32'(0));
    check_eq("zero_done_count", 32'(dones), 32'(1));
    check_eq("zero_done_pos", 32'(done_log[1]), 32'(1));
    check_eq("zero_busy_accept", 32'(busy_log[0]), 32'(1));
    check_eq("zero_busy_fall", 32'(busy_log[2]), 32'(0));

    // Full FIFO: long SHL stalls the sequencer, four more fill the FIFO
    send(OP_SHL, 3'd7, 8'h00, w);
    send(OP_LOAD, 3'd5, 8'h3C, w);
    check_eq("full_fill_wait", 32'(w), 32'(0));
    send(OP_SHR, 3'd1, 8'h00, w);
    check_eq("full_fill_wait", 32'(w), 32'(0));
    send(OP_LSHL, 3'd2, 8'hF0, w);
    check_eq("full_fill_wait", 32'(w), 32'(0));
    send(OP_SHL, 3'd0, 8'h00, w);
    check_eq("full_fill_wait", 32'(w), 32'(0));
    check_eq("full_ready_low", 32'(cmd_ready), 32'(0));
    check_eq("full_busy", 32'(busy), 32'(1));
    send(OP_SHR, 3'd3, 8'h00, w);
    check_eq("full_wait_for_pop", 32'(w), 32'(6));
    wait_idle("full_drain");
    check_eq("full_sb_empty", 32'(exp_q.size() + done_q.size()), 32'(0));
    check_eq("full_data_hold", 32'(data_in), 32'(8'hF0));

    // Reset in the 3rd shift cycle of SHR 5
    send(OP_SHR, 3'd5, 8'h00, w);
    repeat (3) tick();
    check_eq("rst_mid_en_before", 32'(enable), 32'(1));
    reset = 1'b0;
    #1;
    check_eq("rst_mid_enable", 32'(enable), 32'(0));
    check_eq("rst_mid_data_in", 32'(data_in), 32'(0));
    check_eq("rst_mid_busy", 32'(busy), 32'(0));
    check_eq("rst_mid_dir", 32'(shift_direction), 32'(0));
    exp_q.delete();
    done_q.delete();
    run_cnt   = 0;
    last_load = '0;
    sr_model  = '0;
    tick();
    reset = 1'b1;
    clear_logs();
    repeat (6) tick();
    check_eq("rst_mid_ready", 32'(cmd_ready), 32'(1));
    ones = 0;
    dones = 0;
    foreach (en_log[i]) ones += int'(en_log[i]);
    foreach (done_log[i]) dones += int'(done_log[i]);
    check_eq("rst_mid_no_enable", 32'(ones), 32'(0));
    check_eq("rst_mid_no_done", 32'(dones), 32'(0));

    // Flush during the 2nd shift cycle of the first of three queued commands
    send(OP_SHL, 3'd5, 8'h00, w);
    send(OP_SHR, 3'd2, 8'h00, w);
    send(OP_SHL, 3'd1, 8'h00, w);
    check_eq("flush_pre_en", 32'(enable), 32'(1));
    flush     = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = OP_SHR;
    cmd_count = 3'd3;
    cmd_data  = 8'h00;
    #1;
    check_eq("flush_ready_low", 32'(cmd_ready), 32'(0));
    tick();
    flush     = 1'b0;
    cmd_valid = 1'b0;
    check_eq("flush_enable", 32'(enable), 32'(0));
    check_eq("flush_busy", 32'(busy), 32'(0));
    check_eq("flush_done", 32'(done), 32'(0));
    exp_q.delete();
    done_q.delete();
    run_cnt = 0;
    clear_logs();
    repeat (8) tick();
    ones = 0;
    dones = 0;
    foreach (en_log[i]) ones += int'(en_log[i]);
    foreach (done_log[i]) dones += int'(done_log[i]);
    check_eq("flush_no_enable", 32'(ones), 32'(0));
    check_eq("flush_no_done", 32'(dones), 32'(0));

    // Recovery after flush
    send(OP_LSHL, 3'd1, 8'h5A, w);
    wait_idle("recover_drain");
    check_eq("recover_model", 32'(sr_model), 32'(8'hB4));
    check_eq("final_sb_empty", 32'(exp_q.size() + done_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Command sequencer that sits directly upstream of the 8-bit shift register stage and drives its `enable`, `shift_direction` and `data_in` inputs. It accepts load/shift commands over a valid/ready handshake, buffers them in a small FIFO, and expands each command into a load cycle and/or a counted run of shift cycles. It never issues shift-register mode `01` (partial-hold mode); only `11` load, `00` shift-left and `10` shift-right are used.

## Interface
- `WIDTH`, 8: data width; matches the shift register.
- `CNT_W`, 3: width of the shift count field.
- `DEPTH`, 4: command FIFO depth; must be a power of 2, at least 2.

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: FIFO can accept.
- `cmd_op` in 2: command opcode.
  - `00` LOAD.
  - `01` SHL.
  - `10` SHR.
  - `11` LOAD_SHL.
- `cmd_count` in CNT_W: number of shift cycles.
- `cmd_data` in WIDTH: load value.
- `flush` in 1: synchronous abort.
- `enable` out 1: to the shift register `enable`.
- `shift_direction` out 2: to the shift register `shift_direction`.
- `data_in` out WIDTH: to the shift register `data_in`.
- `busy` out 1: FIFO non-empty or FSM not in IDLE.
- `done` out 1: one-cycle pulse when a command retires.

## Operation
- **Handshake**
  - A command is pushed on the rising edge where `cmd_valid && cmd_ready`.
  - `cmd_ready = !full && !flush`.
  - No pop-through when full: `cmd_ready` stays low even in a cycle where the FSM pops.
- **FIFO**
  - DEPTH entries of {op, count, data}.
  - Pointers are log2(DEPTH)+1 bits wide, giving a wrap-safe full/empty test.
  - Push and pop in the same cycle are both honoured.
- **FSM states:** IDLE, LOAD, SHIFT, RETIRE.
- **IDLE**
  - If the FIFO is non-empty: pop the head into the working registers.
  - Op LOAD or LOAD_SHL: go to LOAD.
  - Op SHL/SHR with count ≠ 0: go to SHIFT.
  - Op SHL/SHR with count = 0: go to RETIRE (no enable issued).
- **LOAD** (one cycle)
  - Outputs: `enable=1`, `shift_direction=11`, `data_in=cmd data`.
  - Next state: SHIFT if op is LOAD_SHL and count ≠ 0; otherwise RETIRE.
- **SHIFT**
  - Outputs: `enable=1`; `shift_direction=00` for SHL/LOAD_SHL, `10` for SHR.
  - The remaining counter decrements each cycle.
  - Leaves for RETIRE after exactly `count` cycles.
- **RETIRE**
  - `enable=0`, `done=1` for one cycle, then go to IDLE.
- **Output registers**
  - `enable`, `shift_direction`, `data_in` and `done` are registered, so they change only on a clock edge.
  - `data_in` holds its last loaded value outside LOAD.
  - `shift_direction` returns to `00` whenever `enable=0`.
- **Count arithmetic**
  - `cmd_count` is unsigned; the maximum run is 2^CNT_W−1 shifts.
  - No wrap: the counter stops at 0.
- **flush** (sampled on an edge)
  - Empties the FIFO and forces IDLE.
  - `enable=0` from that edge on; no `done` for the aborted command.
  - A `cmd_valid` in the same cycle is dropped because `cmd_ready` is low.
- **Reset**
  - Asynchronous and immediate, including mid-command.
  - Values: FIFO empty, FSM IDLE, `enable=0`, `shift_direction=00`, `data_in=0`, `done=0`, `busy=0`, `cmd_ready=1`.

## Timing
- **Accept-to-first-enable latency:** command accepted at edge k; popped at edge k+1; `enable` is high during cycle k+1→k+2.
- **Operation counts:**
  - LOAD: 1 enable cycle.
  - SHL/SHR with count N: N consecutive enable cycles.
  - LOAD_SHL with count N: N+1 consecutive enable cycles (load first).
- **Between commands:** exactly two `enable=0` cycles (RETIRE, then IDLE pop), so back-to-back commands never merge.
- **done:** high for exactly one cycle, the cycle after the last enable cycle.
- **busy:** rises the cycle after the first accept; falls in the cycle after RETIRE when the FIFO is empty.
- **Full:** after DEPTH accepts with no pop, `cmd_ready=0`. It returns to 1 the cycle after a pop.

## Test plan
- **Reset mid-SHIFT:**
  - Stimulus: SHR count=5; assert `reset=0` during the 3rd shift cycle.
  - Required: `enable=0`, `data_in=0`, `busy=0` immediately; after release, `cmd_ready=1` and no `done`.
- **LOAD_SHL:**
  - Stimulus: LOAD_SHL data=8'hA5 count=3.
  - Required: one cycle `11`/`A5`, then three cycles `00`; `done` one cycle later. A shift register model ends at 8'h28.
- **Back-to-back:**
  - Stimulus: LOAD 8'h81 then SHR count=2.
  - Required: `enable` pattern 1,0,0,1,1; `shift_direction` 11,00,00,10,10; two `done` pulses. Model ends at 8'h20.
- **Full FIFO:**
  - Stimulus: stall the FSM with SHL count=7, then push 4 more commands; hold `cmd_valid`.
  - Required: `cmd_ready=0` after the FIFO fills; the next push is accepted only after the first pop; all 5 commands retire in order.
- **Zero count:**
  - Stimulus: SHL count=0.
  - Required: no enable cycle; `done` pulses 2 cycles after accept.
- **Flush:**
  - Stimulus: 3 queued commands; assert `flush` during the 2nd SHIFT cycle of the first, with `cmd_valid` also high.
  - Required: `enable=0` next cycle; FIFO empty; the same-cycle command is dropped; no `done`; `busy=0` next cycle.
